bus_master: RTL and testbench

Single-outstanding initiator for the shared `addr`/`data`/`size`/`rw` system bus, sitting between the CPU's memory pipeline stage and all memory-mapped responders (RAM, performance counter at 0x8000_0000, etc.). It accepts one load/store request at a time over a valid/ready handshake, runs one bus transaction with a configurable number of wait cycles, and returns the read data sign- or zero-extended with a one-cycle response pulse. It is the initiator counterpart of the existing bus responders and uses the same size encoding and right-justified data convention.

---
 rtl/bus_master.sv | 144 ++++++++++++++
 tb/tb_bus_master.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master.sv
// Single-outstanding load/store initiator for the shared addr/data/size/rw system bus.
// Define BUS_MASTER_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning down.
module bus_master #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] bus_addr_o,
  inout  wire  [31:0] bus_data_io,
  output logic [1:0]  bus_size_o,
  output logic        bus_rw_o
);

  typedef enum logic [1:0] {StIdle, StAddr, StWait, StDone} state_e;

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q, uns_q, drive_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic        req_ready_q, rsp_valid_q, rsp_err_q, bus_rw_q;
  logic [31:0] rsp_rdata_q, bus_addr_q;
  logic [1:0]  bus_size_q;

  logic [31:0] addr_aligned, wdata_masked, load_data;
  logic        req_err, last_bus_cycle;

  always_comb begin
    addr_aligned = req_addr_i;
    wdata_masked = req_wdata_i;
    case (req_size_i)
      2'b01: wdata_masked = {24'h0, req_wdata_i[7:0]};
      2'b10: begin
        addr_aligned = {req_addr_i[31:1], 1'b0};
        wdata_masked = {16'h0, req_wdata_i[15:0]};
      end
      2'b11: addr_aligned = {req_addr_i[31:2], 2'b00};
      default: ;
    endcase
`ifdef BUS_MASTER_MISALIGN_TRAP_EN
    req_err = (req_size_i == 2'b00) || (addr_aligned != req_addr_i);
`else
    req_err = (req_size_i == 2'b00);
`endif
  end

  always_comb begin
    case (size_q)
      2'b01:   load_data = {{24{~uns_q & bus_data_io[7]}}, bus_data_io[7:0]};
      2'b10:   load_data = {{16{~uns_q & bus_data_io[15]}}, bus_data_io[15:0]};
      default: load_data = bus_data_io;
    endcase
    // The edge ending the final bus cycle both samples read data and releases the bus.
    last_bus_cycle = ((state_q == StAddr) && (WAIT_CYCLES <= 1)) ||
                     ((state_q == StWait) && (cnt_q == 4'd1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= '0;
      wdata_q     <= '0;
      drive_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      bus_addr_q  <= '0;
      bus_size_q  <= '0;
      bus_rw_q    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            we_q        <= req_we_i;
            size_q      <= req_size_i;
            uns_q       <= req_unsigned_i;
            req_ready_q <= 1'b0;
            if (req_err) begin
              state_q     <= StDone;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q    <= StAddr;
              bus_addr_q <= addr_aligned;
              bus_size_q <= req_size_i;
              bus_rw_q   <= req_we_i;
              drive_q    <= req_we_i;
              wdata_q    <= wdata_masked;
            end
          end
        end
        StAddr, StWait: begin
          if (last_bus_cycle) begin
            state_q     <= StDone;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= we_q ? 32'h0 : load_data;
            bus_addr_q  <= '0;
            bus_size_q  <= '0;
            bus_rw_q    <= 1'b0;
            drive_q     <= 1'b0;
          end else if (state_q == StAddr) begin
            state_q <= StWait;
            cnt_q   <= WaitInit;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDone: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus_data_io = drive_q ? wdata_q : 'z;
  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_size_o  = bus_size_q;
  assign bus_rw_o    = bus_rw_q;

endmodule

// File: tb/tb_bus_master.sv
// Bench for bus_master: two instances (WAIT_CYCLES 1 and 3) checked every cycle against a
// transaction-timeline model, plus directed requests with hand-computed results.
`timescale 1ns/1ps
module tb_bus_master;
  localparam int W0 = 1;
  localparam int W1 = 3;
  localparam logic [31:0] Probe = 32'h5A5A_A5A5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        vld [2];
  logic        req_we, req_uns;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rdy [2], rv [2], rerr [2], rw [2];
  logic [31:0] rd [2], ba [2];
  logic [1:0]  bs [2];
  wire  [31:0] bd0, bd1;
  logic        drv [2] = '{1'b1, 1'b1};
  logic [31:0] val [2] = '{Probe, Probe};

  // Bench side of the bus: responder data during loads, a probe pattern whenever the DUT must
  // be released (including the whole reset window).
  assign bd0 = (drv[0] || !rst_n) ? val[0] : 'z;
  assign bd1 = (drv[1] || !rst_n) ? val[1] : 'z;

  bus_master #(.WAIT_CYCLES(W0)) u_dut_w1 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(vld[0]), .req_ready_o(rdy[0]),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_uns),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rv[0]),
    .rsp_rdata_o(rd[0]), .rsp_err_o(rerr[0]), .bus_addr_o(ba[0]), .bus_data_io(bd0),
    .bus_size_o(bs[0]), .bus_rw_o(rw[0])
  );

  bus_master #(.WAIT_CYCLES(W1)) u_dut_w3 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(vld[1]), .req_ready_o(rdy[1]),
    .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_uns),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rv[1]),
    .rsp_rdata_o(rd[1]), .rsp_err_o(rerr[1]), .bus_addr_o(ba[1]), .bus_data_io(bd1),
    .bus_size_o(bs[1]), .bus_rw_o(rw[1])
  );

  // Model: per instance, the current transaction and the edge number it was accepted on.
  int          wc [2] = '{W0, W1};
  bit          act [2], t_err [2], t_we [2];
  int          acc [2];
  logic [31:0] t_addr [2], t_wd [2], t_rd [2], t_resp [2], rsp_val [2];
  logic [1:0]  t_size [2];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic bit bus_phase(input int i);
    return act[i] && !t_err[i] && ((cyc - acc[i]) < wc[i]);
  endfunction

  function automatic bit rsp_phase(input int i);
    return act[i] && ((cyc - acc[i]) == (t_err[i] ? 0 : wc[i]));
  endfunction

  function automatic void model_accept(input int i);
    longint nb, span, raw;
    nb   = (req_size == 2'd1) ? 1 : (req_size == 2'd2) ? 2 : 4;
    span = longint'(1) << (8 * nb);
    act[i]    = 1'b1;
    acc[i]    = cyc;
    t_we[i]   = req_we;
    t_size[i] = req_size;
    t_resp[i] = rsp_val[i];
    t_addr[i] = 32'(longint'(req_addr) - (longint'(req_addr) % nb));
`ifdef BUS_MASTER_MISALIGN_TRAP_EN
    t_err[i] = (req_size == 2'd0) || ((longint'(req_addr) % nb) != 0);
`else
    t_err[i] = (req_size == 2'd0);
`endif
    t_wd[i] = 32'(longint'(req_wdata) % span);
    raw = longint'(rsp_val[i]) % span;
    if (!req_uns && raw >= span / 2) raw = raw - span;
    t_rd[i] = (t_err[i] || req_we) ? 32'h0 : 32'(raw);
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s u%0d cyc %0d: got %08h want %08h", name, inst, cyc, got, want);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) act[i] = 1'b0;
      else if (!act[i]) begin
        if (vld[i]) model_accept(i);
      end else if ((cyc - acc[i]) > (t_err[i] ? 0 : wc[i])) act[i] = 1'b0;
      drv[i] <= !(bus_phase(i) && t_we[i]);
      val[i] <= (bus_phase(i) && !t_we[i]) ? t_resp[i] : Probe;
    end
  end

  bit          c_bus, c_rsp;
  logic [31:0] c_bd;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      c_bus = rst_n && bus_phase(i);
      c_rsp = rst_n && rsp_phase(i);
      c_bd  = (i == 0) ? bd0 : bd1;
      chk("req_ready", i, 32'(rdy[i]), 32'(!rst_n || !act[i]));
      chk("bus_addr", i, ba[i], c_bus ? t_addr[i] : 32'h0);
      chk("bus_size", i, 32'(bs[i]), c_bus ? 32'(t_size[i]) : 32'h0);
      chk("bus_rw", i, 32'(rw[i]), 32'(c_bus && t_we[i]));
      chk("bus_data", i, c_bd, (c_bus && t_we[i]) ? t_wd[i] : val[i]);
      chk("rsp_valid", i, 32'(rv[i]), 32'(c_rsp));
      chk("rsp_err", i, 32'(rerr[i]), 32'(c_rsp && t_err[i]));
      chk("rsp_rdata", i, rd[i], c_rsp ? t_rd[i] : 32'h0);
    end
  end

  task automatic do_req(input int i, input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] resp);
    int n = 0;
    rsp_val[i] = resp;
    req_we     = we;
    req_size   = sz;
    req_uns    = uns;
    req_addr   = ad;
    req_wdata  = wd;
    vld[i]     = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(act[i] && acc[i] == cyc) && n < 40);
    vld[i] = 1'b0;
    if (!(act[i] && acc[i] == cyc)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout u%0d: got no accept want accept within 40 cycles", i);
    end
  endtask

  // Latency is counted in cycles after the accept edge (cycle 1 = first bus cycle).
  task automatic wait_rsp(input int i, input string tag, input logic [31:0] e_rd,
                          input logic e_err, input int e_cyc, input logic [31:0] e_ba,
                          input logic [1:0] e_bs, input logic [31:0] e_bd);
    int n = 0;
    bit got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({tag, "_bus_addr"}, i, ba[i], e_ba);
        chk({tag, "_bus_size"}, i, 32'(bs[i]), 32'(e_bs));
        chk({tag, "_bus_data"}, i, (i == 0) ? bd0 : bd1, e_bd);
      end
      got = rv[i];
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout u%0d: got no rsp_valid want rsp_valid", tag, i);
    end else begin
      chk({tag, "_rdata"}, i, rd[i], e_rd);
      chk({tag, "_err"}, i, 32'(rerr[i]), 32'(e_err));
      chk({tag, "_cycle"}, i, 32'(n), 32'(e_cyc));
    end
  endtask

  int gap, n_wait, pulses;
  initial begin
    vld       = '{1'b0, 1'b0};
    rsp_val   = '{32'h0, 32'h0};
    req_we    = 1'b0;
    req_uns   = 1'b0;
    req_size  = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 0, 32'(rdy[0]), 32'h1);
    chk("reset_bus_size", 1, 32'(bs[1]), 32'h0);
    chk("reset_rdata", 1, rd[1], 32'h0);

    do_req(0, 1'b0, 2'b11, 1'b0, 32'h8000_0000, 32'h0, 32'h0000_00F5);
    wait_rsp(0, "lw_perf", 32'h0000_00F5, 1'b0, 2, 32'h8000_0000, 2'b11, 32'h0000_00F5);
    do_req(0, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h0000_0080);
    wait_rsp(0, "lb", 32'hFFFF_FF80, 1'b0, 2, 32'h10, 2'b01, 32'h0000_0080);
    do_req(0, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0000_0080);
    wait_rsp(0, "lbu", 32'h0000_0080, 1'b0, 2, 32'h10, 2'b01, 32'h0000_0080);
    do_req(0, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 32'h1234_8001);
    wait_rsp(0, "lh", 32'hFFFF_8001, 1'b0, 2, 32'h06, 2'b10, 32'h1234_8001);
    do_req(0, 1'b0, 2'b10, 1'b1, 32'h06, 32'h0, 32'h1234_8001);
    wait_rsp(0, "lhu", 32'h0000_8001, 1'b0, 2, 32'h06, 2'b10, 32'h1234_8001);
    do_req(0, 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 32'h1234_567F);
    wait_rsp(0, "lb_pos", 32'h0000_007F, 1'b0, 2, 32'h13, 2'b01, 32'h1234_567F);
    do_req(0, 1'b1, 2'b01, 1'b0, 32'h07, 32'h1122_33C4, 32'h0);
    wait_rsp(0, "sb", 32'h0, 1'b0, 2, 32'h07, 2'b01, 32'h0000_00C4);

    do_req(1, 1'b1, 2'b10, 1'b0, 32'h22, 32'hDEAD_BEEF, 32'h0);
    wait_rsp(1, "sh", 32'h0, 1'b0, 4, 32'h22, 2'b10, 32'h0000_BEEF);
    do_req(1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h8765_4321);
    wait_rsp(1, "lw_w3", 32'h8765_4321, 1'b0, 4, 32'h100, 2'b11, 32'h8765_4321);

    do_req(0, 1'b0, 2'b11, 1'b0, 32'h1002, 32'h0, 32'hCAFE_0001);
`ifdef BUS_MASTER_MISALIGN_TRAP_EN
    wait_rsp(0, "lw_mis", 32'h0, 1'b1, 1, 32'h0, 2'b00, Probe);
`else
    wait_rsp(0, "lw_mis", 32'hCAFE_0001, 1'b0, 2, 32'h1000, 2'b11, 32'hCAFE_0001);
`endif
    do_req(1, 1'b1, 2'b00, 1'b0, 32'h30, 32'hFFFF_FFFF, 32'h0);
    wait_rsp(1, "size0", 32'h0, 1'b1, 1, 32'h0, 2'b00, Probe);

    // Back-to-back: valid held high, responses must be WAIT_CYCLES+2 apart.
    @(negedge clk);
    rsp_val[1] = 32'h0000_0042;
    req_we     = 1'b0;
    req_size   = 2'b11;
    req_uns    = 1'b0;
    req_addr   = 32'h200;
    vld[1]     = 1'b1;
    n_wait     = 0;
    do begin
      @(negedge clk);
      n_wait++;
    end while (!rv[1] && n_wait < 40);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!rv[1] && gap < 40);
    vld[1] = 1'b0;
    chk("b2b_gap", 1, 32'(gap), 32'(W1 + 2));
    repeat (2) @(negedge clk);

    // Reset in the middle of a store's wait phase.
    do_req(1, 1'b1, 2'b11, 1'b0, 32'h40, 32'h0BAD_F00D, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_bus_size", 1, 32'(bs[1]), 32'h3);
    rst_n = 1'b0;
    #1;
    chk("rst_bus_size", 1, 32'(bs[1]), 32'h0);
    chk("rst_ready", 1, 32'(rdy[1]), 32'h1);
    chk("rst_bus_data", 1, bd1, Probe);
    chk("rst_rsp_valid", 1, 32'(rv[1]), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (rv[1]) pulses++;
    end
    chk("rst_no_rsp", 1, 32'(pulses), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test want end within 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
